// File: rtl/pc_stack.sv
// pc_stack: program-counter bank with call/return stack pointer.
//
// One bank entry per call level. The entry at index sp is the active PC.
// A call (push) saves the return address by incrementing the active entry,
// then opens the next entry at the call target. A return (pop) moves sp back
// so the saved return address becomes active again.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset
//   inc      increment active entry
//   load     write target into active entry (jump)
//   push     call: save return address, open new entry at target
//   pop      return: discard active entry
//   target   jump/call destination
//   clr_err  clear sticky error
//   pc_out   active entry value, bank[sp]
//   sp_out   active entry index
//   full     sp == DEPTH-1
//   empty    sp == 0
//   err      sticky error flag
//   err_code first error since last clear: 00 none, 01 overflow,
//            10 underflow, 11 push/pop conflict
module pc_stack #(
    parameter int              PC_W     = 9,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    localparam int             SP_W     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] target,
    input  logic            clr_err,
    output logic [PC_W-1:0] pc_out,
    output logic [SP_W-1:0] sp_out,
    output logic            full,
    output logic            empty,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam logic [SP_W-1:0] SP_TOP = SP_W'(DEPTH - 1);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_OVERFLOW = 2'b01;
    localparam logic [1:0] CODE_UNDERFLW = 2'b10;
    localparam logic [1:0] CODE_CONFLICT = 2'b11;

    logic [PC_W-1:0] bank [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_up;

    logic conflict, do_push, do_pop, do_load, do_inc;
    logic overflow, underflow;
    logic raise;
    logic [1:0] raise_code;

    assign pc_out = bank[sp];
    assign sp_out = sp;
    assign full   = (sp == SP_TOP);
    assign empty  = (sp == '0);
    assign sp_up  = sp + SP_W'(1);

    // Priority: conflict > push > pop > load > inc. Any push or pop request,
    // legal or not, suppresses load and inc for that cycle.
    always_comb begin
        conflict  = push & pop;
        do_push   = push & ~pop & ~full;
        overflow  = push & ~pop & full;
        do_pop    = pop & ~push & ~empty;
        underflow = pop & ~push & empty;
        do_load   = load & ~push & ~pop;
        do_inc    = inc & ~load & ~push & ~pop;

        raise      = conflict | overflow | underflow;
        raise_code = CODE_NONE;
        if (conflict)
            raise_code = CODE_CONFLICT;
        else if (overflow)
            raise_code = CODE_OVERFLOW;
        else if (underflow)
            raise_code = CODE_UNDERFLW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp_up;
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Only bank[sp] and, on a push, bank[sp+1] are ever addressed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                bank[i] <= RESET_PC;
            end else if (SP_W'(i) == sp) begin
                if (do_push || do_inc)
                    bank[i] <= bank[i] + PC_W'(1);
                else if (do_load)
                    bank[i] <= target;
            end else if (do_push && SP_W'(i) == sp_up) begin
                bank[i] <= target;
            end
        end
    end

    // err_code keeps the first error; a clear in the same cycle as a new
    // error lets the new error's code through.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= CODE_NONE;
        end else if (raise) begin
            err <= 1'b1;
            if (!err || clr_err)
                err_code <= raise_code;
        end else if (clr_err) begin
            err      <= 1'b0;
            err_code <= CODE_NONE;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed bench for pc_stack (PC_W=9, DEPTH=8, RESET_PC=0).
// Stimulus issues one operation per cycle and queues the hand-computed
// expected state after the edge; a monitor pops and compares each cycle.
module tb_pc_stack;

    localparam int PC_W  = 9;
    localparam int DEPTH = 8;
    localparam int SP_W  = 3;

    logic            clk = 1'b0;
    logic            rst, inc, load, push, pop, clr_err;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_out;
    logic [SP_W-1:0] sp_out;
    logic            full, empty, err;
    logic [1:0]      err_code;

    typedef struct {
        string name;
        int    pc;
        int    sp;
        int    err;
        int    code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .load     (load),
        .push     (push),
        .pop      (pop),
        .target   (target),
        .clr_err  (clr_err),
        .pc_out   (pc_out),
        .sp_out   (sp_out),
        .full     (full),
        .empty    (empty),
        .err      (err),
        .err_code (err_code)
    );

    task automatic check(input string name, input string field, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, act, expv);
        end
    endtask

    // Monitor: state is presented every cycle, compared whenever an
    // expectation is outstanding for the edge that just occurred.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, "pc_out",   int'(pc_out),   e.pc);
                check(e.name, "sp_out",   int'(sp_out),   e.sp);
                check(e.name, "full",     int'(full),     (e.sp == DEPTH - 1) ? 1 : 0);
                check(e.name, "empty",    int'(empty),    (e.sp == 0) ? 1 : 0);
                check(e.name, "err",      int'(err),      e.err);
                check(e.name, "err_code", int'(err_code), e.code);
            end
        end
    end

    task automatic step(input string name,
                        input bit r, input bit i, input bit l, input bit pu, input bit po,
                        input bit c, input int t,
                        input int e_pc, input int e_sp, input int e_err, input int e_code);
        exp_t e;
        @(negedge clk);
        rst = r; inc = i; load = l; push = pu; pop = po; clr_err = c;
        target = PC_W'(t);
        e.name = name; e.pc = e_pc; e.sp = e_sp; e.err = e_err; e.code = e_code;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; inc = 1'b0; load = 1'b0; push = 1'b0; pop = 1'b0;
        clr_err = 1'b0; target = '0;

        //        name            rst inc ld push pop clr target  pc     sp err code
        // Reset and call/return
        step("reset",         1, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
        step("inc1",          0, 1, 0, 0, 0, 0, 'h000, 'h001, 0, 0, 0);
        step("inc2",          0, 1, 0, 0, 0, 0, 'h000, 'h002, 0, 0, 0);
        step("inc3",          0, 1, 0, 0, 0, 0, 'h000, 'h003, 0, 0, 0);
        step("call40",        0, 1, 1, 1, 0, 0, 'h040, 'h040, 1, 0, 0);
        step("inc_in_call",   0, 1, 0, 0, 0, 0, 'h000, 'h041, 1, 0, 0);
        step("ret",           0, 1, 0, 0, 1, 0, 'h000, 'h004, 0, 0, 0);

        // Fill to the top, then overflow
        step("reset_b",       1, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
        for (int k = 1; k < DEPTH; k++)
            step($sformatf("fill%0d", k), 0, 0, 0, 1, 0, 0, 'h10 + k, 'h10 + k, k, 0, 0);
        step("overflow",      0, 1, 0, 1, 0, 0, 'h099, 'h017, 7, 1, 1);
        step("pop_after_ovf", 0, 0, 0, 0, 1, 0, 'h000, 'h017, 6, 1, 1);
        step("pop_ignore_ld", 0, 0, 1, 0, 1, 0, 'h1AA, 'h016, 5, 1, 1);
        step("conflict_keep", 0, 0, 0, 1, 1, 0, 'h055, 'h016, 5, 1, 1);

        // Underflow, conflict and clear interplay
        step("reset_c",       1, 1, 1, 1, 1, 1, 'h0AA, 'h000, 0, 0, 0);
        step("underflow",     0, 0, 0, 0, 1, 0, 'h000, 'h000, 0, 1, 2);
        step("conflict_2nd",  0, 0, 0, 1, 1, 0, 'h055, 'h000, 0, 1, 2);
        step("clear",         0, 0, 0, 0, 0, 1, 'h000, 'h000, 0, 0, 0);
        step("conflict",      0, 1, 0, 1, 1, 0, 'h055, 'h000, 0, 1, 3);
        step("clr_with_unf",  0, 0, 0, 0, 1, 1, 'h000, 'h000, 0, 1, 2);
        step("clear2",        0, 0, 0, 0, 0, 1, 'h000, 'h000, 0, 0, 0);
        step("call_clean",    0, 0, 0, 1, 0, 0, 'h020, 'h020, 1, 0, 0);

        // Jump and wrap
        step("reset_d",       1, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
        step("load1ff",       0, 0, 1, 0, 0, 0, 'h1FF, 'h1FF, 0, 0, 0);
        step("wrap",          0, 1, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
        step("load_over_inc", 0, 1, 1, 0, 0, 0, 'h005, 'h005, 0, 0, 0);

        // Reset mid-stack discards everything
        step("call30",        0, 0, 0, 1, 0, 0, 'h030, 'h030, 1, 0, 0);
        step("call31",        0, 0, 0, 1, 0, 0, 'h031, 'h031, 2, 0, 0);
        step("call32",        0, 0, 0, 1, 0, 0, 'h032, 'h032, 3, 0, 0);
        step("reset_mid",     1, 1, 0, 1, 0, 0, 'h0EE, 'h000, 0, 0, 0);
        step("unf_after_rst", 0, 0, 0, 0, 1, 0, 'h000, 'h000, 0, 1, 2);
        step("call77",        0, 0, 0, 1, 0, 0, 'h077, 'h077, 1, 1, 2);
        step("ret_to_1",      0, 0, 0, 0, 1, 0, 'h000, 'h001, 0, 1, 2);

        @(negedge clk);
        rst = 1'b0; inc = 1'b0; load = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("drain", "pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
